// File: rtl/piton_dcr_fifo.sv
// DCR write-message FIFO between Piton core control and the Vortex DCR write port.
// Single clock, valid/ready on both sides, wrap-bit pointers, first-word fall-through.
module piton_dcr_fifo #(
  parameter int unsigned VX_DCR_ADDR_WIDTH = 8,
  parameter int unsigned VX_DCR_DATA_WIDTH = 32,
  parameter int unsigned DEPTH             = 8,
  parameter int unsigned AFULL_THRESH      = DEPTH - 2,
  localparam int unsigned PTR_W            = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [VX_DCR_ADDR_WIDTH-1:0] in_addr,
  input  logic [VX_DCR_DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] out_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] out_data,
  input  logic                         out_ready,
  output logic [PTR_W:0]               count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         overflow
);

  localparam int unsigned   ENT_W     = VX_DCR_ADDR_WIDTH + VX_DCR_DATA_WIDTH;
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] AFULL_CNT = (PTR_W + 1)'(AFULL_THRESH);

  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             r_overflow;
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_count;
  logic [ENT_W-1:0] w_head;

  // Flags decode only from registered pointers; no input-to-output comb path.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign w_push = in_valid & ~w_full;
  assign w_pop  = ~w_empty & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; the write is suppressed while reset or flush is active.
  always_ff @(posedge clk) begin
    if (rst_n && w_push && !flush) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_addr, in_data};
    end
  end

  assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign out_addr    = w_head[ENT_W-1:VX_DCR_DATA_WIDTH];
  assign out_data    = w_head[VX_DCR_DATA_WIDTH-1:0];
  assign out_valid   = ~w_empty;
  assign in_ready    = ~w_full;
  assign count       = w_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (w_count >= AFULL_CNT);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_piton_dcr_fifo.sv
// Directed bench for piton_dcr_fifo: DEPTH=8 default instance and a DEPTH=4 instance.
module tb_piton_dcr_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_out_ready;
  logic [7:0]  a_in_addr, a_out_addr;
  logic [31:0] a_in_data, a_out_data;
  logic        a_in_ready, a_out_valid, a_empty, a_full, a_afull, a_overflow;
  logic [3:0]  a_count;

  logic        b_flush, b_in_valid, b_out_ready;
  logic [7:0]  b_in_addr, b_out_addr;
  logic [31:0] b_in_data, b_out_data;
  logic        b_in_ready, b_out_valid, b_empty, b_full, b_afull, b_overflow;
  logic [2:0]  b_count;

  int n_assert = 0;
  int n_fail   = 0;

  piton_dcr_fifo u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_addr(a_in_addr), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_addr(a_out_addr), .out_data(a_out_data), .out_ready(a_out_ready),
    .count(a_count), .empty(a_empty), .full(a_full), .almost_full(a_afull), .overflow(a_overflow)
  );

  piton_dcr_fifo #(.DEPTH(4), .AFULL_THRESH(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_addr(b_in_addr), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_addr(b_out_addr), .out_data(b_out_data), .out_ready(b_out_ready),
    .count(b_count), .empty(b_empty), .full(b_full), .almost_full(b_afull), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_addr = '0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_addr = '0; b_in_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset / idle
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_afull", a_afull, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst4_count", b_count, 0);
    chk("rst4_empty", b_empty, 1);

    // Fill DEPTH=8; almost_full first at count 6
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1; a_in_addr = 8'(i); a_in_data = 32'hA000_0000 | 32'(i);
      step();
      chk("fill_count", a_count, 64'(i + 1));
      chk("fill_afull", a_afull, (i + 1 >= 6) ? 64'd1 : 64'd0);
    end
    a_in_valid = 0;
    chk("fill_full", a_full, 1);
    chk("fill_in_ready", a_in_ready, 0);
    chk("fill_out_valid", a_out_valid, 1);
    chk("fill_head_addr", a_out_addr, 8'h00);

    // Overflow attempt while full
    a_in_valid = 1; a_in_addr = 8'hFF; a_in_data = 32'hDEAD_BEEF;
    step();
    a_in_valid = 0;
    chk("ovf_set", a_overflow, 1);
    chk("ovf_count", a_count, 8);
    step();
    chk("ovf_sticky", a_overflow, 1);

    // Drain in order
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", a_out_valid, 1);
      chk("drain_addr", a_out_addr, 64'(i));
      chk("drain_data", a_out_data, 64'(32'hA000_0000 | 32'(i)));
      step();
    end
    a_out_ready = 0;
    chk("drain_empty", a_empty, 1);
    chk("drain_count", a_count, 0);
    chk("drain_ovf_kept", a_overflow, 1);

    a_flush = 1;
    step();
    a_flush = 0;
    chk("flush_ovf", a_overflow, 0);
    chk("flush_count", a_count, 0);
    chk("flush_empty", a_empty, 1);

    // Concurrent push/pop at count 3 for 20 cycles
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_addr = 8'(8'h10 + i); a_in_data = 32'hC000_0000 + 32'(8'h10 + i);
      step();
    end
    chk("cc_count_start", a_count, 3);
    for (int k = 0; k < 20; k++) begin
      a_in_valid = 1; a_in_addr = 8'(8'h13 + k); a_in_data = 32'hC000_0000 + 32'(8'h13 + k);
      a_out_ready = 1;
      chk("cc_head_addr", a_out_addr, 64'(8'h10 + k));
      chk("cc_head_data", a_out_data, 64'(32'hC000_0000 + 32'(8'h10 + k)));
      step();
      chk("cc_count", a_count, 3);
    end
    a_in_valid = 0;
    for (int k = 20; k < 23; k++) begin
      chk("cc_tail_addr", a_out_addr, 64'(8'h10 + k));
      step();
    end
    a_out_ready = 0;
    chk("cc_empty", a_empty, 1);

    // Flush priority over push and pop at count 5
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1; a_in_addr = 8'(8'h30 + i); a_in_data = 32'h3000_0000 + 32'(i);
      step();
    end
    chk("fp_count5", a_count, 5);
    a_flush = 1; a_in_valid = 1; a_in_addr = 8'h77; a_in_data = 32'h7777_7777; a_out_ready = 1;
    step();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    chk("fp_count", a_count, 0);
    chk("fp_empty", a_empty, 1);
    chk("fp_out_valid", a_out_valid, 0);
    chk("fp_in_ready", a_in_ready, 1);
    step();
    chk("fp_still_empty", a_empty, 1);
    a_in_valid = 1; a_in_addr = 8'h88; a_in_data = 32'h8888_0000;
    step();
    a_in_valid = 0;
    chk("fp_new_head", a_out_addr, 8'h88);
    a_out_ready = 1;
    step();
    a_out_ready = 0;
    chk("fp_drained", a_empty, 1);

    // Async reset mid-cycle at count 4
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_addr = 8'(8'h40 + i); a_in_data = 32'h4000_0000 + 32'(i);
      step();
    end
    a_in_valid = 0;
    chk("ar_count4", a_count, 4);
    #3;
    rst_n = 0;
    #1;
    chk("ar_out_valid", a_out_valid, 0);
    chk("ar_count", a_count, 0);
    chk("ar_in_ready", a_in_ready, 1);
    step();
    rst_n = 1;
    step();
    a_in_valid = 1; a_in_addr = 8'h55; a_in_data = 32'h5555_AAAA;
    step();
    a_in_valid = 0;
    chk("ar_new_count", a_count, 1);
    chk("ar_new_addr", a_out_addr, 8'h55);
    chk("ar_new_data", a_out_data, 32'h5555_AAAA);
    a_out_ready = 1;
    step();
    a_out_ready = 0;
    chk("ar_new_empty", a_empty, 1);

    // DEPTH=4, AFULL_THRESH=3 fill and drain
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1; b_in_addr = 8'(i); b_in_data = 32'hA000_0000 | 32'(i);
      step();
      chk("d4_count", b_count, 64'(i + 1));
      chk("d4_afull", b_afull, (i + 1 >= 3) ? 64'd1 : 64'd0);
    end
    chk("d4_full", b_full, 1);
    chk("d4_in_ready", b_in_ready, 0);
    b_in_addr = 8'hFF; b_in_data = 32'hDEAD_BEEF;
    step();
    b_in_valid = 0;
    chk("d4_ovf", b_overflow, 1);
    b_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("d4_valid", b_out_valid, 1);
      chk("d4_addr", b_out_addr, 64'(i));
      chk("d4_data", b_out_data, 64'(32'hA000_0000 | 32'(i)));
      step();
    end
    b_out_ready = 0;
    chk("d4_empty", b_empty, 1);
    b_flush = 1;
    step();
    b_flush = 0;
    chk("d4_flush_ovf", b_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/piton_dcr_fifo.md
Name: piton_dcr_fifo

Overview:
Parametrised DCR write-message FIFO between the Piton core-control logic and the Vortex DCR write port. It replaces the fixed 8-entry buffer with configurable depth and widths. It adds true full/empty detection using a wrap bit, an occupancy count, an almost-full flag, a sticky overflow error, and a synchronous flush. Both sides use a single-clock valid/ready handshake; any clock-domain crossing is handled outside this block.

Parameters:
VX_DCR_ADDR_WIDTH, 8, DCR address width in bits
VX_DCR_DATA_WIDTH, 32, DCR data width in bits
DEPTH, 8, number of entries; power of 2, >=2
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH
(Derived: PTR_W = log2(DEPTH); pointers are PTR_W+1 bits; count is PTR_W+1 bits.)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all contents and of overflow
in_valid  in  1  core control presents a DCR write
in_addr  in  VX_DCR_ADDR_WIDTH  DCR address
in_data  in  VX_DCR_DATA_WIDTH  DCR data
in_ready  out  1  FIFO can accept; equals ~full
out_valid  out  1  head entry valid toward Vortex; equals ~empty
out_addr  out  VX_DCR_ADDR_WIDTH  head address
out_data  out  VX_DCR_DATA_WIDTH  head data
out_ready  in  1  Vortex accepts head this cycle
count  out  PTR_W+1  occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count>=AFULL_THRESH
overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, overflow=0. Outputs: count=0, empty=1, full=0, in_ready=1, out_valid=0, almost_full=0. Storage array is not reset; out_addr/out_data are don't-care while empty.
- Push = in_valid & in_ready. On a push, the entry is written at mem[wr_ptr[PTR_W-1:0]] and wr_ptr increments, modulo 2^(PTR_W+1).
- Pop = out_valid & out_ready. On a pop, rd_ptr increments.
- empty: wr_ptr == rd_ptr.
- full: the low PTR_W bits of the pointers are equal and the MSBs differ.
- count = wr_ptr - rd_ptr, modulo 2^(PTR_W+1). All flags decode from registered pointers, so there is no combinational path from in_valid or out_ready to any output.
- First-word fall-through: out_addr/out_data are a combinational read of mem[rd_ptr]. A push at edge N makes out_valid=1 from cycle N+1, so latency is 1 cycle.
- Simultaneous push and pop (not full, not empty): both occur, count is unchanged, and order is preserved.
- Push while full: in_ready=0, so no write occurs, even if a pop happens in the same cycle (no bypass). If in_valid=1 while full, overflow sets at the next edge and stays set until flush or reset. Stored data is untouched.
- Pop while empty: impossible (out_valid=0). out_ready is ignored.
- flush=1 at an edge: pointers return to 0 and overflow clears. Flush takes priority over push, pop and the overflow set in the same cycle. Outputs match post-reset state from the next cycle.
- Wrap-around: pointers wrap naturally. Data order and count must stay correct across any number of wraps.
- Upstream must hold in_valid/in_addr/in_data stable until accepted. The block holds out_* stable while out_valid & ~out_ready.
- Reset asserted mid-transfer: all in-flight entries are discarded immediately, with no partial write.

Test Plan:
- Reset/idle: deassert rst_n after 3 cycles with no traffic -> count=0, empty=1, in_ready=1, out_valid=0, overflow=0.
- Fill and drain (DEPTH=8): push addr=i, data=0xA000_000i for i=0..7 with out_ready=0 -> full=1, count=8, almost_full first asserts at count=6. Then drain with out_ready=1 -> outputs appear in order i=0..7, empty=1 after 8 pops.
- Overflow: while full, drive in_valid=1 for one cycle with addr=0xFF -> no write, overflow=1. Drain -> 0xFF never appears. Pulse flush -> overflow=0, count=0.
- Concurrent push/pop: at count=3, push and pop every cycle for 20 cycles -> count stays 3, pointers wrap at least twice, every value emerges in order.
- Flush priority: at count=5, assert flush together with in_valid and out_ready -> next cycle count=0, empty=1, and the pushed entry is never output.
- Async reset mid-stream: drop rst_n mid-cycle at count=4 -> out_valid=0 and count=0 before the next clk edge. After release, the FIFO accepts new data normally; repeat the fill and drain with DEPTH=4, AFULL_THRESH=3.
